// File: rtl/list_eval_pkg.sv
// rtl/list_eval_pkg.sv - shared lisp types: tags, ops, error codes, evaluator states
package list_eval_pkg;

    typedef enum logic [1:0] {
        TAG_NUM  = 2'd0,
        TAG_CONS = 2'd1,
        TAG_NIL  = 2'd2,
        TAG_SYM  = 2'd3
    } tag_t;

    typedef enum logic [1:0] {
        OP_SUM   = 2'd0,
        OP_COUNT = 2'd1,
        OP_MAX   = 2'd2,
        OP_AND   = 2'd3
    } op_t;

    // Which word of the expression the outstanding read is fetching
    typedef enum logic [1:0] {
        RD_TOP = 2'd0,
        RD_CAR = 2'd1,
        RD_CDR = 2'd2
    } rd_kind_t;

    localparam logic [3:0] STATE_ERROR = 4'd0;
    localparam logic [3:0] FETCH_ERROR = 4'd1;
    localparam logic [3:0] EVAL_ERROR  = 4'd2;
    localparam logic [3:0] APPLY_ERROR = 4'd3;
    localparam logic [3:0] STEP_ERROR  = 4'd4;

    // FETCH issues the top-level read; CAR and CDR issue the list-walk reads
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_WAIT  = 3'd2,
        S_CAR   = 3'd3,
        S_CDR   = 3'd4,
        S_DONE  = 3'd5,
        S_ERROR = 3'd6
    } state_t;

endpackage

// File: rtl/list_alu.sv
// rtl/list_alu.sv - combinational fold of one list element into the accumulator
module list_alu
    import list_eval_pkg::*;
#(
    parameter int DATA_W = 14
) (
    input  logic [DATA_W-1:0] acc,
    input  logic [DATA_W-1:0] elem,
    input  op_t               op,
    input  logic              first,
    output logic [DATA_W-1:0] acc_next,
    output logic              carry
);

    // AND starts from all-ones, so the first element simply replaces the accumulator
    always_comb begin
        acc_next = acc;
        carry    = 1'b0;
        case (op)
            OP_SUM:   {carry, acc_next} = {1'b0, acc} + {1'b0, elem};
            OP_COUNT: {carry, acc_next} = {1'b0, acc} + {{DATA_W{1'b0}}, 1'b1};
            OP_MAX:   acc_next = (first || (elem > acc)) ? elem : acc;
            OP_AND:   acc_next = first ? elem : (acc & elem);
            default:  acc_next = acc;
        endcase
    end

endmodule

// File: rtl/list_eval.sv
// rtl/list_eval.sv - tagged-word evaluator reducing cons lists over a fixed-latency memory port
module list_eval
    import list_eval_pkg::*;
#(
    parameter int WORD_W      = 16,
    parameter int TAG_W       = 2,
    parameter int ADDR_W      = 14,
    parameter int MEM_LATENCY = 1,
    parameter int MAX_CELLS   = 256
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [ADDR_W-1:0]         start_addr,
    input  logic [1:0]                op,
    output logic                      mem_rd,
    output logic [ADDR_W-1:0]         mem_addr,
    input  logic [WORD_W-1:0]         mem_data,
    output logic                      busy,
    output logic                      done,
    output logic [WORD_W-TAG_W-1:0]   result,
    output logic                      overflow,
    output logic                      error,
    output logic [3:0]                error_code
);

    localparam int DATA_W = WORD_W - TAG_W;
    localparam int CNT_W  = $clog2(MAX_CELLS + 1);
    localparam logic [3:0]       LAT       = 4'(MEM_LATENCY);
    localparam logic [CNT_W-1:0] CELLS_MAX = CNT_W'(MAX_CELLS);

    state_t            state, state_n;
    rd_kind_t          kind, kind_n;
    op_t               op_q, op_n;
    logic [ADDR_W-1:0] ptr, ptr_n;
    logic [3:0]        lat_cnt, lat_n;
    logic [CNT_W-1:0]  cells, cells_n;
    logic [DATA_W-1:0] acc, acc_n;
    logic              first, first_n;
    logic [DATA_W-1:0] result_n;
    logic              ovf_n;
    logic [3:0]        code_n;

    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] payload;
    logic [ADDR_W-1:0] link;
    logic              is_num, is_cons, is_nil;
    logic              data_valid;
    logic [DATA_W-1:0] alu_acc;
    logic              alu_carry;

    assign tag        = mem_data[WORD_W-1 -: TAG_W];
    assign payload    = mem_data[DATA_W-1:0];
    assign link       = payload[ADDR_W-1:0];
    assign is_num     = (tag == TAG_W'(TAG_NUM));
    assign is_cons    = (tag == TAG_W'(TAG_CONS));
    assign is_nil     = (tag == TAG_W'(TAG_NIL));
    assign data_valid = (lat_cnt == 4'd1);

    assign mem_rd   = (state == S_FETCH) || (state == S_CAR) || (state == S_CDR);
    assign mem_addr = ptr;
    assign busy     = mem_rd || (state == S_WAIT);
    assign done     = (state == S_DONE);
    assign error    = (state == S_ERROR);

    list_alu #(.DATA_W(DATA_W)) u_alu (
        .acc      (acc),
        .elem     (payload),
        .op       (op_q),
        .first    (first),
        .acc_next (alu_acc),
        .carry    (alu_carry)
    );

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_n;
    end

    // Next-state and datapath updates; each read is issue, wait L cycles, consume
    always_comb begin
        state_n  = state;
        kind_n   = kind;
        op_n     = op_q;
        ptr_n    = ptr;
        lat_n    = lat_cnt;
        cells_n  = cells;
        acc_n    = acc;
        first_n  = first;
        result_n = result;
        ovf_n    = overflow;
        code_n   = error_code;
        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    op_n     = op_t'(op);
                    ptr_n    = start_addr;
                    kind_n   = RD_TOP;
                    result_n = '0;
                    ovf_n    = 1'b0;
                    cells_n  = '0;
                    acc_n    = '0;
                    first_n  = 1'b1;
                    state_n  = S_FETCH;
                end
            end
            S_FETCH, S_CAR, S_CDR: begin
                lat_n   = LAT;
                state_n = S_WAIT;
            end
            S_WAIT: begin
                if (!data_valid) begin
                    lat_n = lat_cnt - 4'd1;
                end else begin
                    lat_n = 4'd0;
                    case (kind)
                        RD_TOP: begin
                            if (is_num) begin
                                result_n = payload;
                                state_n  = S_DONE;
                            end else if (is_nil) begin
                                result_n = '0;
                                state_n  = S_DONE;
                            end else if (is_cons) begin
                                ptr_n   = link;
                                kind_n  = RD_CAR;
                                state_n = S_CAR;
                            end else begin
                                code_n  = EVAL_ERROR;
                                state_n = S_ERROR;
                            end
                        end
                        RD_CAR: begin
                            if (is_num) begin
                                acc_n   = alu_acc;
                                ovf_n   = overflow | alu_carry;
                                first_n = 1'b0;
                                ptr_n   = ptr + 1'b1;
                                kind_n  = RD_CDR;
                                state_n = S_CDR;
                            end else begin
                                code_n  = APPLY_ERROR;
                                state_n = S_ERROR;
                            end
                        end
                        RD_CDR: begin
                            if (is_nil) begin
                                result_n = first ? '0 : acc;
                                state_n  = S_DONE;
                            end else if (is_cons) begin
                                if (cells == CELLS_MAX) begin
                                    code_n  = STEP_ERROR;
                                    state_n = S_ERROR;
                                end else begin
                                    cells_n = cells + 1'b1;
                                    ptr_n   = link;
                                    kind_n  = RD_CAR;
                                    state_n = S_CAR;
                                end
                            end else begin
                                code_n  = APPLY_ERROR;
                                state_n = S_ERROR;
                            end
                        end
                        default: begin
                            code_n  = STATE_ERROR;
                            state_n = S_ERROR;
                        end
                    endcase
                end
            end
            S_ERROR: begin
                state_n = S_ERROR;
            end
            default: begin
                code_n  = STATE_ERROR;
                state_n = S_ERROR;
            end
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            kind       <= RD_TOP;
            op_q       <= OP_SUM;
            ptr        <= '0;
            lat_cnt    <= 4'd0;
            cells      <= '0;
            acc        <= '0;
            first      <= 1'b1;
            result     <= '0;
            overflow   <= 1'b0;
            error_code <= 4'd0;
        end else begin
            kind       <= kind_n;
            op_q       <= op_n;
            ptr        <= ptr_n;
            lat_cnt    <= lat_n;
            cells      <= cells_n;
            acc        <= acc_n;
            first      <= first_n;
            result     <= result_n;
            overflow   <= ovf_n;
            error_code <= code_n;
        end
    end

endmodule

// File: tb/tb_list_eval.sv
// tb/tb_list_eval.sv - directed self-checking bench for list_eval
module tb_list_eval;

    localparam int L  = 2;
    localparam int MC = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [13:0] start_addr;
    logic [1:0]  op;
    logic        mem_rd;
    logic [13:0] mem_addr;
    logic [15:0] mem_data;
    logic        busy;
    logic        done;
    logic [13:0] result;
    logic        overflow;
    logic        error;
    logic [3:0]  error_code;

    int checks = 0;
    int errors = 0;
    int lat;
    int reads;

    logic [15:0] mem [0:16383];
    logic [13:0] pa [0:L-1];
    logic        pv [0:L-1];

    list_eval #(
        .WORD_W(16), .TAG_W(2), .ADDR_W(14), .MEM_LATENCY(L), .MAX_CELLS(MC)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .start_addr (start_addr),
        .op         (op),
        .mem_rd     (mem_rd),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .busy       (busy),
        .done       (done),
        .result     (result),
        .overflow   (overflow),
        .error      (error),
        .error_code (error_code)
    );

    always #5 clk = ~clk;

    // Fixed-latency memory; outside the valid cycle it returns a SYM word
    always @(posedge clk) begin
        pv[0] <= mem_rd;
        pa[0] <= mem_addr;
        for (int i = 1; i < L; i++) begin
            pv[i] <= pv[i-1];
            pa[i] <= pa[i-1];
        end
    end
    assign mem_data = pv[L-1] ? mem[pa[L-1]] : 16'hFFFF;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called #1 after an edge; start is high for this cycle (cycle 0)
    task automatic run_eval(input logic [13:0] a, input logic [1:0] o, input int poke,
                            output int lat_o, output int reads_o);
        start = 1'b1; start_addr = a; op = o;
        @(posedge clk); #1;
        lat_o = -1; reads_o = 0;
        for (int k = 1; k <= 200; k++) begin
            if (k == poke) begin
                start = 1'b1; start_addr = 14'h010; op = 2'd1;
            end else begin
                start = 1'b0;
            end
            if (mem_rd) reads_o++;
            if (done || error) begin
                lat_o = k;
                break;
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        for (int i = 0; i < 16384; i++) mem[i] = 16'hC000;
        mem[14'h010] = 16'h0123;
        mem[14'h030] = 16'h4020;
        mem[14'h020] = 16'h0001; mem[14'h021] = 16'h4022;
        mem[14'h022] = 16'h0002; mem[14'h023] = 16'h4024;
        mem[14'h024] = 16'h0003; mem[14'h025] = 16'h8000;
        mem[14'h050] = 16'h4044;
        mem[14'h044] = 16'h000F; mem[14'h045] = 16'h4046;
        mem[14'h046] = 16'h003C; mem[14'h047] = 16'h8000;
        mem[14'h060] = 16'h8000;
        mem[14'h070] = 16'h4071;
        mem[14'h071] = 16'h3FFF; mem[14'h072] = 16'h4073;
        mem[14'h073] = 16'h0001; mem[14'h074] = 16'h8000;
        mem[14'h080] = 16'h4081;
        mem[14'h081] = 16'h0005; mem[14'h082] = 16'h4081;
        mem[14'h090] = 16'hC000;
        mem[14'h0A0] = 16'h40A1;
        mem[14'h0A1] = 16'hC000;

        rst = 1'b0; start = 1'b0; start_addr = '0; op = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_mem_rd", 32'(mem_rd), 0);
        chk("rst_mem_addr", 32'(mem_addr), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_result", 32'(result), 0);
        chk("rst_overflow", 32'(overflow), 0);
        chk("rst_error", 32'(error), 0);
        chk("rst_code", 32'(error_code), 0);
        rst = 1'b1;
        @(posedge clk); #1;

        run_eval(14'h010, 2'd0, -1, lat, reads);
        chk("num_result", 32'(result), 32'h0123);
        chk("num_done_cyc", 32'(lat), L + 2);
        chk("num_reads", 32'(reads), 1);
        chk("num_busy", 32'(busy), 0);

        run_eval(14'h060, 2'd0, -1, lat, reads);
        chk("nil_result", 32'(result), 0);
        chk("nil_done_cyc", 32'(lat), L + 2);

        run_eval(14'h030, 2'd0, -1, lat, reads);
        chk("sum3_result", 32'(result), 6);
        chk("sum3_done_cyc", 32'(lat), 22);
        chk("sum3_reads", 32'(reads), 7);
        chk("sum3_ovf", 32'(overflow), 0);

        run_eval(14'h050, 2'd2, -1, lat, reads);
        chk("max_result", 32'(result), 32'h3C);
        chk("max_done_cyc", 32'(lat), 16);
        run_eval(14'h050, 2'd3, -1, lat, reads);
        chk("and_result", 32'(result), 32'h0C);
        run_eval(14'h050, 2'd1, -1, lat, reads);
        chk("count_result", 32'(result), 2);
        run_eval(14'h050, 2'd0, -1, lat, reads);
        chk("sum2_result", 32'(result), 32'h4B);

        run_eval(14'h070, 2'd0, -1, lat, reads);
        chk("wrap_result", 32'(result), 0);
        chk("wrap_ovf", 32'(overflow), 1);

        run_eval(14'h030, 2'd0, 3, lat, reads);
        chk("poke_result", 32'(result), 6);
        chk("poke_done_cyc", 32'(lat), 22);
        chk("poke_ovf_cleared", 32'(overflow), 0);

        start = 1'b1; start_addr = 14'h030; op = 2'd0;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        chk("mid_busy_before", 32'(busy), 1);
        rst = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_mem_rd", 32'(mem_rd), 0);
        chk("mid_rst_result", 32'(result), 0);
        chk("mid_rst_done", 32'(done), 0);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("mid_after_busy", 32'(busy), 0);
        chk("mid_after_done", 32'(done), 0);
        chk("mid_after_error", 32'(error), 0);
        run_eval(14'h010, 2'd0, -1, lat, reads);
        chk("mid_clean_result", 32'(result), 32'h0123);
        chk("mid_clean_done_cyc", 32'(lat), L + 2);

        run_eval(14'h090, 2'd0, -1, lat, reads);
        chk("symtop_error", 32'(error), 1);
        chk("symtop_code", 32'(error_code), 2);
        chk("symtop_cyc", 32'(lat), L + 2);
        run_eval(14'h010, 2'd0, -1, lat, reads);
        @(posedge clk); #1;
        chk("sticky_error", 32'(error), 1);
        chk("sticky_done", 32'(done), 0);
        chk("sticky_busy", 32'(busy), 0);
        chk("sticky_result", 32'(result), 0);
        chk("sticky_code", 32'(error_code), 2);

        do_reset();
        chk("post_rst_error", 32'(error), 0);
        run_eval(14'h0A0, 2'd0, -1, lat, reads);
        chk("symelem_code", 32'(error_code), 3);
        chk("symelem_cyc", 32'(lat), 7);

        do_reset();
        run_eval(14'h080, 2'd2, -1, lat, reads);
        chk("cyc_error", 32'(error), 1);
        chk("cyc_code", 32'(error_code), 4);
        chk("cyc_reads", 32'(reads), 11);
        chk("cyc_err_cyc", 32'(lat), 34);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
